// File: rtl/rom_fetch_arbiter_pkg.sv
// rom_fetch_arbiter_pkg: shared FSM state encoding and grant identifiers for the ROM fetch arbiter
package rom_fetch_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_DATA = 2'd1,
        B_LO   = 2'd2,
        B_HI   = 2'd3
    } state_t;
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;
endpackage

// File: rtl/rom_fetch_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, favours the port not granted last when both request
module rr_arb2
    import rom_fetch_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last_gnt;
    // One-hot grant; A wins a tie only when B was granted last
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = en & req[0] & (~req[1] | (last_gnt == GNT_B));
        gnt[1] = en & req[1] & ~gnt[0];
    end
    // Remember the most recent grant to alternate on contention
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_gnt <= GNT_B;
        else
            last_gnt <= gnt[0] ? GNT_A : gnt[1] ? GNT_B : last_gnt;
    end
endmodule

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one registered-read ROM port between a 16-bit and a 32-bit requester
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            resetn,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_dout,
    input  logic            a_req,
    input  logic [AW-1:0]   a_addr,
    output logic            a_ack,
    output logic            a_rvalid,
    output logic [DW-1:0]   a_rdata,
    input  logic            b_req,
    input  logic [AW-1:0]   b_addr,
    output logic            b_ack,
    output logic            b_rvalid,
    output logic [2*DW-1:0] b_rdata
);
    state_t        state, state_nxt;
    logic [DW-1:0] lo_q;
    logic [AW-1:0] baddr_q;
    logic          issue;
    logic [1:0]    gnt;

    // B_LO is busy fetching the high half; reset also blocks issue so acks clear at once
    assign issue = resetn && (state != B_LO);

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({b_req, a_req}),
        .en     (issue),
        .gnt    (gnt)
    );

    // Issue decision, ROM address mux, return data and next state
    always_comb begin
        a_ack     = gnt[0];
        b_ack     = gnt[1];
        a_rvalid  = (state == A_DATA);
        b_rvalid  = (state == B_HI);
        a_rdata   = a_rvalid ? rom_dout : '0;
        b_rdata   = b_rvalid ? {rom_dout, lo_q} : '0;
        rom_addr  = (state == B_LO) ? baddr_q + 1'b1 : gnt[0] ? a_addr : gnt[1] ? b_addr : '0;
        state_nxt = (state == B_LO) ? B_HI : gnt[0] ? A_DATA : gnt[1] ? B_LO : IDLE;
    end

    // State register plus low-half data and B address capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            lo_q    <= '0;
            baddr_q <= '0;
        end else begin
            state   <= state_nxt;
            lo_q    <= (state == B_LO) ? rom_dout : lo_q;
            baddr_q <= gnt[1] ? b_addr : baddr_q;
        end
    end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter: scoreboard bench for rom_fetch_arbiter with a behavioural XOR-pattern ROM
module tb_rom_fetch_arbiter;
    logic        clk = 0;
    logic        resetn = 0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        a_req = 0, b_req = 0;
    logic [9:0]  a_addr = 0, b_addr = 0;
    logic        a_ack, b_ack, a_rvalid, b_rvalid;
    logic [15:0] a_rdata;
    logic [31:0] b_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int na_ack = 0, nb_ack = 0, na_rv = 0, nb_rv = 0;
    logic prev_b = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    rom_fetch_arbiter #(.AW(10), .DW(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_ack    (a_ack),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_ack    (b_ack),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [9:0] a);
        return {6'b0, a} ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        rom_dout <= rom_f(rom_addr);
        cyc = cyc + 1;
    end

    // Scoreboard: push on ack, pop on rvalid, check data and latency
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] hi;
        if (!resetn) begin
            qa.delete();
            qb.delete();
            prev_b = 0;
            na_ack = 0; nb_ack = 0; na_rv = 0; nb_rv = 0;
        end else begin
            checks++;
            if (a_ack && b_ack) begin errors++; $display("FAIL ack_overlap a_ack=%b b_ack=%b required not both", a_ack, b_ack); end
            checks++;
            if (a_rvalid && b_rvalid) begin errors++; $display("FAIL rvalid_overlap a_rvalid=%b b_rvalid=%b required not both", a_rvalid, b_rvalid); end
            if (prev_b) begin
                checks++;
                if (a_ack || b_ack) begin errors++; $display("FAIL ack_in_b_lo a_ack=%b b_ack=%b required 0 0", a_ack, b_ack); end
            end
            if (a_rvalid) begin
                na_rv++;
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL a_spurious a_rvalid=1 required 0 at cycle %0d", cyc);
                end else begin
                    e = qa.pop_front();
                    if (a_rdata !== e.d[15:0] || cyc != e.c) begin
                        errors++; $display("FAIL a_data got %h@%0d required %h@%0d", a_rdata, cyc, e.d[15:0], e.c);
                    end
                end
            end
            if (b_rvalid) begin
                nb_rv++;
                checks++;
                if (qb.size() == 0) begin
                    errors++; $display("FAIL b_spurious b_rvalid=1 required 0 at cycle %0d", cyc);
                end else begin
                    e = qb.pop_front();
                    if (b_rdata !== e.d || cyc != e.c) begin
                        errors++; $display("FAIL b_data got %h@%0d required %h@%0d", b_rdata, cyc, e.d, e.c);
                    end
                end
            end
            if (a_ack) begin
                na_ack++;
                e.d = {16'h0, rom_f(a_addr)};
                e.c = cyc + 1;
                qa.push_back(e);
            end
            if (b_ack) begin
                nb_ack++;
                hi = b_addr + 10'd1;
                e.d = {rom_f(hi), rom_f(b_addr)};
                e.c = cyc + 2;
                qb.push_back(e);
            end
            prev_b = b_ack;
        end
    end

    task automatic do_reset();
        resetn = 0;
        a_req = 0; b_req = 0; a_addr = 0; b_addr = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0;
        a_req = 1; b_req = 1; a_addr = 10'h123; b_addr = 10'h234;
        #1;
        checks++;
        if ({a_ack, b_ack, a_rvalid, b_rvalid} !== 4'b0 || rom_addr !== 10'h0) begin
            errors++; $display("FAIL reset_outputs acks/rvalids=%b rom_addr=%h required 0000 000", {a_ack, b_ack, a_rvalid, b_rvalid}, rom_addr);
        end
        do_reset();
    endtask

    task automatic test_single_a();
        a_req = 1; a_addr = 10'h010;
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || rom_addr !== 10'h010) begin errors++; $display("FAIL single_a_ack a_ack=%b rom_addr=%h required 1 010", a_ack, rom_addr); end
        @(posedge clk); #1 a_req = 0;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'hA5B5) begin errors++; $display("FAIL single_a_data rvalid=%b data=%h required 1 a5b5", a_rvalid, a_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_b_wrap();
        b_req = 1; b_addr = 10'h3FF;
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1 || rom_addr !== 10'h3FF) begin errors++; $display("FAIL b_wrap_ack b_ack=%b rom_addr=%h required 1 3ff", b_ack, rom_addr); end
        @(posedge clk); #1 b_req = 0;
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b0 || b_rvalid !== 1'b0 || rom_addr !== 10'h000) begin errors++; $display("FAIL b_wrap_hi_addr b_ack=%b b_rvalid=%b rom_addr=%h required 0 0 000", b_ack, b_rvalid, rom_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'hA5A5_A65A) begin errors++; $display("FAIL b_wrap_data rvalid=%b data=%h required 1 a5a5a65a", b_rvalid, b_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_both();
        string seq = "";
        do_reset();
        a_req = 1; b_req = 1; a_addr = 10'h100; b_addr = 10'h200;
        repeat (6) begin
            @(negedge clk);
            if (a_ack) seq = {seq, "A"};
            if (b_ack) seq = {seq, "B"};
            @(posedge clk); #1;
        end
        a_req = 0; b_req = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (seq != "ABAB") begin errors++; $display("FAIL both_grants got %s required ABAB", seq); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [4] = '{16'hA5A4, 16'hA5A7, 16'hA5A6, 16'hA5A1};
        int acks = 0;
        for (int i = 0; i < 5; i++) begin
            a_req = (i < 4);
            a_addr = 10'(i + 1);
            @(negedge clk);
            if (a_ack) acks++;
            if (i > 0) begin
                checks++;
                if (a_rvalid !== 1'b1 || a_rdata !== exp_d[i-1]) begin errors++; $display("FAIL b2b_data[%0d] rvalid=%b data=%h required 1 %h", i - 1, a_rvalid, a_rdata, exp_d[i-1]); end
            end
            @(posedge clk); #1;
        end
        a_req = 0;
        checks++;
        if (acks != 4) begin errors++; $display("FAIL b2b_acks got %0d required 4", acks); end
    endtask

    task automatic test_reset_mid();
        b_req = 1; b_addr = 10'h055;
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1) begin errors++; $display("FAIL mid_b_ack b_ack=%b required 1", b_ack); end
        @(posedge clk); #1 b_req = 0;
        resetn = 0;
        #1;
        checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || rom_addr !== 10'h0) begin errors++; $display("FAIL mid_reset_clear a_rv=%b b_rv=%b rom_addr=%h required 0 0 000", a_rvalid, b_rvalid, rom_addr); end
        @(posedge clk); #1 resetn = 1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (b_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid b_rvalid=%b required 0", b_rvalid); end
            @(posedge clk); #1;
        end
        a_req = 1; a_addr = 10'h020;
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1) begin errors++; $display("FAIL mid_after_a_ack a_ack=%b required 1", a_ack); end
        @(posedge clk); #1 a_req = 0;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'hA585) begin errors++; $display("FAIL mid_after_a_data rvalid=%b data=%h required 1 a585", a_rvalid, a_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic aa, ba;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            aa = a_ack; ba = b_ack;
            @(posedge clk); #1;
            if (!a_req || aa) begin
                a_req = 1'($urandom_range(0, 1));
                a_addr = 10'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                a_req = 0;
            end
            if (!b_req || ba) begin
                b_req = 1'($urandom_range(0, 1));
                b_addr = 10'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                b_req = 0;
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (na_ack != na_rv || qa.size() != 0) begin errors++; $display("FAIL rand_a_count rvalids=%0d required %0d pending=%0d", na_rv, na_ack, qa.size()); end
        checks++;
        if (nb_ack != nb_rv || qb.size() != 0) begin errors++; $display("FAIL rand_b_count rvalids=%0d required %0d pending=%0d", nb_rv, nb_ack, qb.size()); end
        checks++;
        if (na_ack < 1000 || nb_ack < 500) begin errors++; $display("FAIL rand_activity a_acks=%0d b_acks=%0d required >=1000 >=500", na_ack, nb_ack); end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_b_wrap();
        test_both();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
